// File: rtl/vram_arb_pkg.sv
// Shared constants and enums for the video SRAM slot arbiter.
package vram_arb_pkg;

  localparam int unsigned FRAME_LEN   = 16;
  localparam int unsigned VIDEO_SLOTS = 8;
  localparam int unsigned WIN_LEN     = 4;
  localparam int unsigned SLOT_W      = $clog2(FRAME_LEN);
  localparam int unsigned K_W         = $clog2(WIN_LEN);

  typedef enum logic [1:0] {K_SETUP, K_STROBE, K_HOLD, K_ACK} win_phase_t;

  typedef enum logic [1:0] {OWN_VIDEO, OWN_CPU, OWN_AUX, OWN_NONE} owner_t;

  function automatic logic is_video(input logic [SLOT_W-1:0] s);
    return 32'(s) < VIDEO_SLOTS;
  endfunction

endpackage

// File: rtl/vram_slot_arbiter_rr_pick.sv
// Two-port round-robin grant; last_q remembers who won the previous window.
module vram_rr_pick (
  input  logic clk24,
  input  logic reset,
  input  logic req_cpu,
  input  logic req_aux,
  input  logic upd_en,
  output logic gnt_cpu_c,
  output logic gnt_aux_c
);

  logic last_q, last_d;  // 1: aux was granted last

  always_comb begin
    gnt_cpu_c = req_cpu;
    gnt_aux_c = req_aux;
    if (req_cpu && req_aux) begin
      gnt_cpu_c = last_q;
      gnt_aux_c = ~last_q;
    end
    last_d = last_q;
    if (upd_en && gnt_aux_c) begin
      last_d = 1'b1;
    end else if (upd_en && gnt_cpu_c) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/vram_slot_arbiter.sv
// 16-slot time-division controller for the shared video SRAM.
// Define VRAM_ARB_AUX_EN to enable the aux port and round-robin arbitration.
module vram_slot_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk24,
  input  logic              reset,
  input  logic [ADDR_W-1:0] video_addr,
  output logic              video_slice,
  output logic              ce12,
  output logic              pipe_ab,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_wdata,
  output logic              aux_ack,
  output logic [7:0]        aux_rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic [7:0]        SRAM_DQ,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_we_n
);

  logic [SLOT_W-1:0] slot_q, slot_d;
  win_phase_t        phase_d;
  logic              arb_en_c;
  logic              gnt_cpu_c, gnt_aux_c;
  logic              aux_req_c;

  logic              video_slice_q, video_slice_d;
  logic              ce12_q, ce12_d;
  logic              pipe_ab_q, pipe_ab_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [7:0]        sram_dq_o_q, sram_dq_o_d;
  logic              sram_dq_oe_q, sram_dq_oe_d;
  logic              sram_we_n_q, sram_we_n_d;
  logic              win_we_q, win_we_d;
  owner_t            owner_q, owner_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              aux_ack_q, aux_ack_d;
  logic [7:0]        aux_rdata_q, aux_rdata_d;

  // All outputs are computed for the slot about to begin, so they line up with slot_q.
  assign slot_d   = slot_q + SLOT_W'(1);
  assign phase_d  = win_phase_t'(slot_d[K_W-1:0]);
  assign arb_en_c = !is_video(slot_d) && (phase_d == K_SETUP);

`ifdef VRAM_ARB_AUX_EN
  assign aux_req_c = aux_req;
`else
  logic aux_unused;
  assign aux_unused = aux_req;
  assign aux_req_c  = 1'b0;
`endif

  vram_rr_pick u_rr_pick (
    .clk24     (clk24),
    .reset     (reset),
    .req_cpu   (cpu_req),
    .req_aux   (aux_req_c),
    .upd_en    (arb_en_c),
    .gnt_cpu_c (gnt_cpu_c),
    .gnt_aux_c (gnt_aux_c)
  );

  always_comb begin
    video_slice_d = is_video(slot_d);
    ce12_d        = slot_d[0];
    pipe_ab_d     = pipe_ab_q ^ (slot_d == '0);
    sram_addr_d   = sram_addr_q;
    sram_dq_o_d   = sram_dq_o_q;
    sram_dq_oe_d  = sram_dq_oe_q;
    sram_we_n_d   = 1'b1;
    win_we_d      = win_we_q;
    owner_d       = owner_q;
    cpu_ack_d     = 1'b0;
    aux_ack_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    aux_rdata_d   = aux_rdata_q;

    if (is_video(slot_d)) begin
      owner_d      = OWN_VIDEO;
      sram_addr_d  = video_addr;
      sram_dq_oe_d = 1'b0;
      win_we_d     = 1'b0;
    end else begin
      case (phase_d)
        K_SETUP: begin
          owner_d      = OWN_NONE;
          win_we_d     = 1'b0;
          sram_dq_oe_d = 1'b0;
          if (gnt_cpu_c) begin
            owner_d      = OWN_CPU;
            sram_addr_d  = cpu_addr;
            sram_dq_o_d  = cpu_wdata;
            win_we_d     = cpu_we;
            sram_dq_oe_d = cpu_we;
          end else if (gnt_aux_c) begin
            owner_d      = OWN_AUX;
            sram_addr_d  = aux_addr;
            sram_dq_o_d  = aux_wdata;
            win_we_d     = aux_we;
            sram_dq_oe_d = aux_we;
          end
        end
        K_STROBE: sram_we_n_d = ~win_we_q;
        K_HOLD:   sram_we_n_d = 1'b1;
        K_ACK: begin
          // Read data is captured off the bus at the end of the hold cycle.
          cpu_ack_d = (owner_q == OWN_CPU);
          aux_ack_d = (owner_q == OWN_AUX);
          if (owner_q == OWN_CPU && !win_we_q) begin
            cpu_rdata_d = SRAM_DQ;
          end
          if (owner_q == OWN_AUX && !win_we_q) begin
            aux_rdata_d = SRAM_DQ;
          end
        end
        default: sram_we_n_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      slot_q        <= '0;
      video_slice_q <= 1'b0;
      ce12_q        <= 1'b0;
      pipe_ab_q     <= 1'b0;
      sram_addr_q   <= '0;
      sram_dq_o_q   <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
      win_we_q      <= 1'b0;
      owner_q       <= OWN_VIDEO;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      aux_ack_q     <= 1'b0;
      aux_rdata_q   <= '0;
    end else begin
      slot_q        <= slot_d;
      video_slice_q <= video_slice_d;
      ce12_q        <= ce12_d;
      pipe_ab_q     <= pipe_ab_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_o_q   <= sram_dq_o_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
      win_we_q      <= win_we_d;
      owner_q       <= owner_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      aux_ack_q     <= aux_ack_d;
      aux_rdata_q   <= aux_rdata_d;
    end
  end

  assign video_slice = video_slice_q;
  assign ce12        = ce12_q;
  assign pipe_ab     = pipe_ab_q;
  assign SRAM_ADDR   = sram_addr_q;
  assign sram_dq_o   = sram_dq_o_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign aux_ack     = aux_ack_q;
  assign aux_rdata   = aux_rdata_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for vram_slot_arbiter; frame slots are counted from reset release.
module tb_vram_slot_arbiter;

  logic        clk24 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] video_addr = '0;
  logic        video_slice, ce12, pipe_ab;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        aux_req = 1'b0, aux_we = 1'b0;
  logic [15:0] aux_addr = '0;
  logic [7:0]  aux_wdata = '0;
  logic        aux_ack;
  logic [7:0]  aux_rdata;
  logic [15:0] SRAM_ADDR;
  logic [7:0]  SRAM_DQ = '0;
  logic [7:0]  sram_dq_o;
  logic        sram_dq_oe, sram_we_n;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  vram_slot_arbiter #(.ADDR_W(16)) dut (
    .clk24(clk24), .reset(reset), .video_addr(video_addr),
    .video_slice(video_slice), .ce12(ce12), .pipe_ab(pipe_ab),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk24 = ~clk24;

  task automatic step();
    @(posedge clk24);
    #1;
  endtask

  // Leaves the bench #1 into slot 0, the first cycle with reset low.
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++; if (video_slice !== 1'b0) begin miscompares++; $display("FAIL reset_video_slice got=%b exp=0", video_slice); end
    vectors++; if (ce12 !== 1'b0) begin miscompares++; $display("FAIL reset_ce12 got=%b exp=0", ce12); end
    vectors++; if (pipe_ab !== 1'b0) begin miscompares++; $display("FAIL reset_pipe_ab got=%b exp=0", pipe_ab); end
    vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n); end
    vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL reset_dq_oe got=%b exp=0", sram_dq_oe); end
    vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_ack got=%b exp=0", cpu_ack); end
    vectors++; if (cpu_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_cpu_rdata got=%h exp=00", cpu_rdata); end
    vectors++; if (aux_ack !== 1'b0) begin miscompares++; $display("FAIL reset_aux_ack got=%b exp=0", aux_ack); end
    vectors++; if (aux_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_aux_rdata got=%h exp=00", aux_rdata); end
  endtask

  task automatic test_idle_video();
    logic exp_vs, exp_ce, exp_pab;
    video_addr = 16'h8123;
    do_reset();
    for (int cyc = 0; cyc < 48; cyc++) begin
      int s;
      s = cyc % 16;
      exp_vs  = (s < 8);
      exp_ce  = (s % 2) == 1;
      exp_pab = ((cyc / 16) % 2) == 1;
      if (cyc > 0) begin
        vectors++; if (video_slice !== exp_vs) begin miscompares++; $display("FAIL idle_video_slice cyc=%0d got=%b exp=%b", cyc, video_slice, exp_vs); end
      end
      vectors++; if (ce12 !== exp_ce) begin miscompares++; $display("FAIL idle_ce12 cyc=%0d got=%b exp=%b", cyc, ce12, exp_ce); end
      vectors++; if (pipe_ab !== exp_pab) begin miscompares++; $display("FAIL idle_pipe_ab cyc=%0d got=%b exp=%b", cyc, pipe_ab, exp_pab); end
      vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL idle_we_n cyc=%0d got=%b exp=1", cyc, sram_we_n); end
      vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL idle_dq_oe cyc=%0d got=%b exp=0", cyc, sram_dq_oe); end
      if (s >= 1 && s <= 7) begin
        vectors++; if (SRAM_ADDR !== 16'h8123) begin miscompares++; $display("FAIL idle_sram_addr cyc=%0d got=%h exp=8123", cyc, SRAM_ADDR); end
      end
      step();
    end
  endtask

  task automatic test_cpu_read();
    logic exp_ack;
    do_reset();
    for (int s = 0; s < 16; s++) begin
      if (s == 3) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; end
      SRAM_DQ = (s == 10) ? 8'hA5 : 8'h3C;
      exp_ack = (s == 11);
      vectors++; if (cpu_ack !== exp_ack) begin miscompares++; $display("FAIL rd_cpu_ack slot=%0d got=%b exp=%b", s, cpu_ack, exp_ack); end
      vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL rd_we_n slot=%0d got=%b exp=1", s, sram_we_n); end
      if (s >= 8 && s <= 11) begin
        vectors++; if (SRAM_ADDR !== 16'h1234) begin miscompares++; $display("FAIL rd_sram_addr slot=%0d got=%h exp=1234", s, SRAM_ADDR); end
      end
      if (s == 11 || s == 15) begin
        vectors++; if (cpu_rdata !== 8'hA5) begin miscompares++; $display("FAIL rd_cpu_rdata slot=%0d got=%h exp=a5", s, cpu_rdata); end
      end
      if (s == 11) cpu_req = 1'b0;
      step();
    end
  endtask

  task automatic test_cpu_write();
    logic exp_oe, exp_wen, exp_ack;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 8'h5A;
    for (int s = 0; s < 16; s++) begin
      exp_oe  = (s >= 8 && s <= 11);
      exp_wen = (s != 9);
      exp_ack = (s == 11);
      vectors++; if (sram_dq_oe !== exp_oe) begin miscompares++; $display("FAIL wr_dq_oe slot=%0d got=%b exp=%b", s, sram_dq_oe, exp_oe); end
      vectors++; if (sram_we_n !== exp_wen) begin miscompares++; $display("FAIL wr_we_n slot=%0d got=%b exp=%b", s, sram_we_n, exp_wen); end
      vectors++; if (cpu_ack !== exp_ack) begin miscompares++; $display("FAIL wr_cpu_ack slot=%0d got=%b exp=%b", s, cpu_ack, exp_ack); end
      if (exp_oe) begin
        vectors++; if (sram_dq_o !== 8'h5A) begin miscompares++; $display("FAIL wr_dq_o slot=%0d got=%h exp=5a", s, sram_dq_o); end
        vectors++; if (SRAM_ADDR !== 16'h4000) begin miscompares++; $display("FAIL wr_sram_addr slot=%0d got=%h exp=4000", s, SRAM_ADDR); end
      end
      if (s == 11) cpu_req = 1'b0;
      step();
    end
    cpu_we = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic exp_wen, exp_ack;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 8'h5A;
    for (int s = 0; s < 9; s++) step();
    vectors++; if (sram_we_n !== 1'b0) begin miscompares++; $display("FAIL rst_mid_strobe got=%b exp=0", sram_we_n); end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL rst_mid_we_n i=%0d got=%b exp=1", i, sram_we_n); end
      vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ack i=%0d got=%b exp=0", i, cpu_ack); end
      vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL rst_mid_dq_oe i=%0d got=%b exp=0", i, sram_dq_oe); end
    end
    reset = 1'b0;
    for (int s = 0; s < 16; s++) begin
      exp_wen = (s != 9);
      exp_ack = (s == 11);
      vectors++; if (cpu_ack !== exp_ack) begin miscompares++; $display("FAIL rst_retry_ack slot=%0d got=%b exp=%b", s, cpu_ack, exp_ack); end
      vectors++; if (sram_we_n !== exp_wen) begin miscompares++; $display("FAIL rst_retry_we_n slot=%0d got=%b exp=%b", s, sram_we_n, exp_wen); end
      if (s == 1 || s == 8) begin
        vectors++; if (video_slice !== (s == 1)) begin miscompares++; $display("FAIL rst_retry_video slot=%0d got=%b exp=%b", s, video_slice, s == 1); end
      end
      if (s == 11) cpu_req = 1'b0;
      step();
    end
    cpu_we = 1'b0;
  endtask

`ifdef VRAM_ARB_AUX_EN
  task automatic test_round_robin();
    logic [7:0] dq_val, exp_cpu_rd, exp_aux_rd;
    logic       exp_cack, exp_aack;
    exp_cpu_rd = '0;
    exp_aux_rd = '0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2222;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h3333;
    for (int cyc = 0; cyc < 32; cyc++) begin
      dq_val  = 8'(cyc * 7 + 1);
      SRAM_DQ = dq_val;
      if (cyc == 10 || cyc == 26) exp_cpu_rd = dq_val;
      if (cyc == 14 || cyc == 30) exp_aux_rd = dq_val;
      exp_cack = (cyc == 11 || cyc == 27);
      exp_aack = (cyc == 15 || cyc == 31);
      vectors++; if (cpu_ack !== exp_cack) begin miscompares++; $display("FAIL rr_cpu_ack cyc=%0d got=%b exp=%b", cyc, cpu_ack, exp_cack); end
      vectors++; if (aux_ack !== exp_aack) begin miscompares++; $display("FAIL rr_aux_ack cyc=%0d got=%b exp=%b", cyc, aux_ack, exp_aack); end
      if (exp_cack) begin
        vectors++; if (cpu_rdata !== exp_cpu_rd) begin miscompares++; $display("FAIL rr_cpu_rdata cyc=%0d got=%h exp=%h", cyc, cpu_rdata, exp_cpu_rd); end
      end
      if (exp_aack) begin
        vectors++; if (aux_rdata !== exp_aux_rd) begin miscompares++; $display("FAIL rr_aux_rdata cyc=%0d got=%h exp=%h", cyc, aux_rdata, exp_aux_rd); end
      end
      if (cyc == 8 || cyc == 12) begin
        vectors++; if (SRAM_ADDR !== ((cyc == 8) ? 16'h2222 : 16'h3333)) begin miscompares++; $display("FAIL rr_sram_addr cyc=%0d got=%h", cyc, SRAM_ADDR); end
      end
      step();
    end
    cpu_req = 1'b0;
    aux_req = 1'b0;
  endtask
`else
  task automatic test_back_to_back();
    logic [7:0] dq_val, exp_rd;
    logic       exp_ack;
    exp_rd = '0;
    do_reset();
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h3333; aux_wdata = 8'hEE;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2222;
    for (int cyc = 0; cyc < 48; cyc++) begin
      int s;
      s = cyc % 16;
      dq_val  = 8'(cyc * 7 + 1);
      SRAM_DQ = dq_val;
      if (s == 10 || s == 14) exp_rd = dq_val;
      exp_ack = (s == 11 || s == 15);
      vectors++; if (cpu_ack !== exp_ack) begin miscompares++; $display("FAIL b2b_cpu_ack cyc=%0d got=%b exp=%b", cyc, cpu_ack, exp_ack); end
      vectors++; if (aux_ack !== 1'b0) begin miscompares++; $display("FAIL b2b_aux_ack cyc=%0d got=%b exp=0", cyc, aux_ack); end
      vectors++; if (aux_rdata !== 8'h00) begin miscompares++; $display("FAIL b2b_aux_rdata cyc=%0d got=%h exp=00", cyc, aux_rdata); end
      if (exp_ack) begin
        vectors++; if (cpu_rdata !== exp_rd) begin miscompares++; $display("FAIL b2b_cpu_rdata cyc=%0d got=%h exp=%h", cyc, cpu_rdata, exp_rd); end
      end
      if (s >= 8) begin
        vectors++; if (SRAM_ADDR !== 16'h2222) begin miscompares++; $display("FAIL b2b_sram_addr cyc=%0d got=%h exp=2222", cyc, SRAM_ADDR); end
      end
      step();
    end
    cpu_req = 1'b0;
    aux_req = 1'b0;
    aux_we  = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_idle_video();
    test_cpu_read();
    test_cpu_write();
    test_reset_mid_write();
`ifdef VRAM_ARB_AUX_EN
    test_round_robin();
`else
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
